// File: rtl/sample_ring_writer_if.sv
// Bus bundle for sample_ring_writer: sample sink, RAM port-2 write master, CSR slave and irq.
// The slave modport is the writer's view; master is the surrounding system's view.
interface sample_ring_writer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic                  snk_valid;
    logic [DATA_W-1:0]     snk_data;
    logic                  snk_ready;

    logic [ADDR_W-1:0]     ram_address;
    logic                  ram_chipselect;
    logic                  ram_write;
    logic [DATA_W-1:0]     ram_writedata;
    logic [DATA_W/8-1:0]   ram_byteenable;
    logic                  ram_clken;

    logic [1:0]            csr_address;
    logic                  csr_read;
    logic                  csr_write;
    logic [31:0]           csr_writedata;
    logic [31:0]           csr_readdata;

    logic                  irq;

    modport slave (
        input  snk_valid, snk_data,
        output snk_ready,
        output ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable, ram_clken,
        input  csr_address, csr_read, csr_write, csr_writedata,
        output csr_readdata,
        output irq
    );

    modport master (
        output snk_valid, snk_data,
        input  snk_ready,
        input  ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable, ram_clken,
        output csr_address, csr_read, csr_write, csr_writedata,
        input  csr_readdata,
        input  irq
    );
endinterface

// File: rtl/sample_ring_writer.sv
// Stream-to-RAM ring-buffer writer with Avalon-MM CSR block (CTRL/STATUS/ACK/WATERMARK).
// Define SAMPLE_RING_IRQ_EN to implement the WATERMARK register and the watermark irq.
module sample_ring_writer #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 16,
    parameter int WM_RESET = 64
) (
    input logic clk,
    input logic reset_n,
    sample_ring_writer_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    function automatic cnt_t min_cnt(input logic [7:0] n, input cnt_t c);
        if (int'(n) < int'(c)) return cnt_t'(n);
        return c;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c, input logic inc);
        if (inc && (c != CNT_FULL)) return c + cnt_t'(1);
        return c;
    endfunction

    logic              ctrl_en_q, ctrl_en_d;
    logic              ctrl_mode_q, ctrl_mode_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    cnt_t              count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic              clear, full, ready, accept, ack;
    cnt_t              count_ack;
    logic [ADDR_W-1:0] rd_ptr;
    logic [31:0]       status;
    logic [7:0]        wm_val;
    logic              unused_wdata;

    assign unused_wdata = ^bus.csr_writedata[31:8];

`ifdef SAMPLE_RING_IRQ_EN
    logic [7:0] wm_q, wm_d;

    always_comb begin
        wm_d = wm_q;
        if (bus.csr_write && (bus.csr_address == 2'd3)) wm_d = bus.csr_writedata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wm_q <= 8'(WM_RESET);
        else          wm_q <= wm_d;
    end

    assign wm_val = wm_q;
`else
    localparam int unused_wm_reset = WM_RESET;
    assign wm_val = 8'd0;
`endif

    always_comb begin
        clear     = bus.csr_write && (bus.csr_address == 2'd0) && bus.csr_writedata[2];
        full      = (count_q == CNT_FULL);
        ready     = ctrl_en_q && !(!ctrl_mode_q && full) && !clear;
        accept    = bus.snk_valid && ready;
        ack       = bus.csr_write && (bus.csr_address == 2'd2);
        count_ack = count_q - (ack ? min_cnt(bus.csr_writedata[7:0], count_q) : '0);
        rd_ptr    = wr_ptr_q - count_q[ADDR_W-1:0];

        status                = '0;
        status[ADDR_W-1:0]    = wr_ptr_q;
        status[8 +: ADDR_W]   = rd_ptr;
        status[16 +: CNT_W]   = count_q;
        status[24]            = ovf_q;
        status[25]            = full;

        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            count_d = sat_inc(count_ack, accept);
            if (accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            // Accepting into a still-full ring drops the oldest word.
            if (accept && (count_ack == CNT_FULL)) ovf_d = 1'b1;
        end

        ctrl_en_d   = ctrl_en_q;
        ctrl_mode_d = ctrl_mode_q;
        if (bus.csr_write && (bus.csr_address == 2'd0)) begin
            ctrl_en_d   = bus.csr_writedata[0];
            ctrl_mode_d = bus.csr_writedata[1];
        end

        ram_wr_d   = accept;
        ram_addr_d = accept ? wr_ptr_q : ram_addr_q;
        ram_data_d = accept ? bus.snk_data : ram_data_q;

        rdata_d = '0;
        if (bus.csr_read) begin
            case (bus.csr_address)
                2'd0:    rdata_d = {30'd0, ctrl_mode_q, ctrl_en_q};
                2'd1:    rdata_d = status;
                2'd3:    rdata_d = {24'd0, wm_val};
                default: rdata_d = '0;
            endcase
        end

`ifdef SAMPLE_RING_IRQ_EN
        irq_d = (wm_val != 8'd0) && (int'(count_q) >= int'(wm_val));
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= 1'b0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_en_q   <= ctrl_en_d;
            ctrl_mode_q <= ctrl_mode_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.snk_ready      = ready;
    assign bus.ram_address    = ram_addr_q;
    assign bus.ram_chipselect = ram_wr_q;
    assign bus.ram_write      = ram_wr_q;
    assign bus.ram_writedata  = ram_data_q;
    assign bus.ram_byteenable = '1;
    assign bus.ram_clken      = 1'b1;
    assign bus.csr_readdata   = rdata_q;
    assign bus.irq            = irq_q;
endmodule

// File: tb/tb_sample_ring_writer.sv
// Self-checking bench for sample_ring_writer: CSR vector table, directed ring scenarios,
// and a randomized run against a behavioural ring model.
module tb_sample_ring_writer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sample_ring_writer_if #(.ADDR_W(7), .DATA_W(16)) bus ();

    sample_ring_writer #(.ADDR_W(7), .DATA_W(16), .WM_RESET(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

`ifdef SAMPLE_RING_IRQ_EN
    localparam bit HAS_WM = 1'b1;
`else
    localparam bit HAS_WM = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] tb_ram [128];

    always @(posedge clk)
        if (bus.ram_chipselect && bus.ram_write) tb_ram[bus.ram_address] <= bus.ram_writedata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status_of(input int wr, input int cnt, input bit ovf);
        logic [31:0] s;
        s        = '0;
        s[6:0]   = 7'(wr);
        s[14:8]  = 7'((wr - cnt + 128) % 128);
        s[23:16] = 8'(cnt);
        s[24]    = ovf;
        s[25]    = (cnt == 128);
        return s;
    endfunction

    task automatic do_reset();
        reset_n           = 1'b0;
        bus.snk_valid     = 1'b0;
        bus.snk_data      = '0;
        bus.csr_address   = '0;
        bus.csr_read      = 1'b0;
        bus.csr_write     = 1'b0;
        bus.csr_writedata = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        bus.csr_address = a; bus.csr_writedata = d; bus.csr_write = 1'b1;
        @(posedge clk); #1;
        bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        bus.csr_address = a; bus.csr_read = 1'b1;
        @(posedge clk); #1;
        bus.csr_read = 1'b0;
        d = bus.csr_readdata;
    endtask

    // Holds valid until n samples are taken or the cycle budget runs out.
    task automatic push(input int n, input logic [15:0] base, output int acc);
        int cyc;
        acc = 0; cyc = 0;
        while (acc < n && cyc < n + 20) begin
            bus.snk_valid = 1'b1;
            bus.snk_data  = 16'(base + 16'(acc));
            @(negedge clk);
            if (bus.snk_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.snk_valid = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic run_table();
        vec_t v [11];
        logic [31:0] rd;
        v[0]  = '{0, 2'd1, 32'h0,         32'h0,                       "status_rst"};
        v[1]  = '{0, 2'd0, 32'h0,         32'h0,                       "ctrl_rst"};
        v[2]  = '{0, 2'd3, 32'h0,         HAS_WM ? 32'd64 : 32'd0,     "wm_rst"};
        v[3]  = '{1, 2'd0, 32'h2,         32'h0,                       ""};
        v[4]  = '{0, 2'd0, 32'h0,         32'h2,                       "ctrl_mode"};
        v[5]  = '{1, 2'd0, 32'hFFFF_FFF7, 32'h0,                       ""};
        v[6]  = '{0, 2'd0, 32'h0,         32'h3,                       "ctrl_clr_rd0"};
        v[7]  = '{1, 2'd3, 32'hABCD_0120, 32'h0,                       ""};
        v[8]  = '{0, 2'd3, 32'h0,         HAS_WM ? 32'h20 : 32'h0,     "wm_rw"};
        v[9]  = '{1, 2'd2, 32'h5,         32'h0,                       ""};
        v[10] = '{0, 2'd2, 32'h0,         32'h0,                       "ack_rd"};
        for (int i = 0; i < 11; i++) begin
            if (v[i].is_wr) csr_wr(v[i].addr, v[i].data);
            else begin
                csr_rd(v[i].addr, rd);
                check(v[i].name, rd, v[i].exp);
            end
        end
        csr_rd(2'd1, rd);
        check("status_ack_empty", rd, 32'h0);
        csr_wr(2'd0, 32'h0);
    endtask

    task automatic run_random(input int cycles);
        bit v, w, rd, clr, acc, exp_ready, irq_next;
        int r, consumed, c2, old_wr;
        logic [1:0] a;
        logic [31:0] wd, rexp;
        logic [15:0] d;
        int m_wr, m_cnt, m_wm;
        bit m_ovf, m_en, m_mode;

        m_wr = 0; m_cnt = 0; m_ovf = 0; m_en = 1; m_mode = 0;
        csr_wr(2'd0, 32'h1);
        csr_wr(2'd3, 32'd20);
        m_wm = HAS_WM ? 20 : 0;

        for (int c = 0; c < cycles; c++) begin
            v  = ($urandom_range(0, 9) < 7);
            d  = 16'($urandom);
            r  = $urandom_range(0, 99);
            w  = 0; rd = 0; a = 2'd0; wd = '0;
            if (r < 8) begin
                w = 1; a = 2'd2;
                wd = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20));
            end else if (r < 11) begin
                w = 1; a = 2'd0;
                wd = {29'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 7) != 0)};
            end else if (r < 13) begin
                w = 1; a = 2'd3;
                wd = {24'($urandom), 8'($urandom_range(0, 130))};
            end else if (r < 40) begin
                rd = 1; a = 2'($urandom);
            end

            bus.snk_valid = v; bus.snk_data = d;
            bus.csr_write = w; bus.csr_read = rd; bus.csr_address = a; bus.csr_writedata = wd;

            clr       = w && (a == 2'd0) && wd[2];
            exp_ready = m_en && !(!m_mode && m_cnt == 128) && !clr;
            acc       = v && exp_ready;
            irq_next  = (m_wm != 0) && (m_cnt >= m_wm);
            case (a)
                2'd0:    rexp = {30'd0, m_mode, m_en};
                2'd1:    rexp = status_of(m_wr, m_cnt, m_ovf);
                2'd3:    rexp = 32'(m_wm);
                default: rexp = 32'd0;
            endcase

            @(negedge clk);
            check("rnd_ready", bus.snk_ready, exp_ready);

            old_wr = m_wr;
            if (clr) begin
                m_wr = 0; m_cnt = 0; m_ovf = 0;
            end else begin
                consumed = 0;
                if (w && a == 2'd2) consumed = (int'(wd[7:0]) < m_cnt) ? int'(wd[7:0]) : m_cnt;
                c2 = m_cnt - consumed + (acc ? 1 : 0);
                if (c2 > 128) begin c2 = 128; m_ovf = 1; end
                m_cnt = c2;
                if (acc) m_wr = (m_wr + 1) % 128;
            end
            if (w && a == 2'd0) begin m_en = wd[0]; m_mode = wd[1]; end
            if (HAS_WM && w && a == 2'd3) m_wm = int'(wd[7:0]);

            @(posedge clk); #1;
            bus.csr_write = 1'b0; bus.csr_read = 1'b0;
            check("rnd_ram_write", bus.ram_write, acc);
            check("rnd_ram_cs", bus.ram_chipselect, acc);
            if (acc) begin
                check("rnd_ram_addr", bus.ram_address, old_wr);
                check("rnd_ram_data", bus.ram_writedata, d);
            end
            if (rd) check("rnd_csr_read", bus.csr_readdata, rexp);
            check("rnd_irq", bus.irq, irq_next);
        end
        bus.snk_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int acc;

        // Reset state
        reset_n = 1'b0;
        bus.snk_valid = 1'b0; bus.snk_data = '0;
        bus.csr_address = '0; bus.csr_read = 1'b0; bus.csr_write = 1'b0; bus.csr_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.snk_ready, 1'b0);
        check("rst_ram_write", bus.ram_write, 1'b0);
        check("rst_ram_cs", bus.ram_chipselect, 1'b0);
        check("rst_ram_addr", bus.ram_address, 7'd0);
        check("rst_ram_data", bus.ram_writedata, 16'd0);
        check("rst_byteen", bus.ram_byteenable, 2'b11);
        check("rst_clken", bus.ram_clken, 1'b1);
        check("rst_readdata", bus.csr_readdata, 32'd0);
        check("rst_irq", bus.irq, 1'b0);
        reset_n = 1'b1;

        run_table();

        // Five samples land at addresses 0..4, one cycle after each accept
        csr_wr(2'd0, 32'h1);
        for (int i = 0; i < 5; i++) begin
            bus.snk_valid = 1'b1;
            bus.snk_data  = 16'(16'h1000 + i);
            @(posedge clk); #1;
            check("s5_write", bus.ram_write, 1'b1);
            check("s5_addr", bus.ram_address, i);
            check("s5_data", bus.ram_writedata, 16'h1000 + i);
        end
        bus.snk_valid = 1'b0;
        @(posedge clk); #1;
        check("s5_write_done", bus.ram_write, 1'b0);
        csr_rd(2'd1, rd);
        check("s5_status", rd, status_of(5, 5, 0));

        // Stop-when-full: only 128 of 130 taken
        csr_wr(2'd0, 32'h5);
        push(130, 16'h3000, acc);
        check("full_accepts", acc, 128);
        check("full_ready", bus.snk_ready, 1'b0);
        csr_rd(2'd1, rd);
        check("full_status", rd, status_of(0, 128, 0));

        // Overwrite mode: 130 taken, oldest two replaced
        csr_wr(2'd0, 32'h7);
        push(130, 16'h2000, acc);
        check("ovw_accepts", acc, 130);
        csr_rd(2'd1, rd);
        check("ovw_status", rd, status_of(2, 128, 1));
        check("ovw_ram0", tb_ram[0], 16'h2080);
        check("ovw_ram1", tb_ram[1], 16'h2081);
        check("ovw_ram2", tb_ram[2], 16'h2002);

        // Accept and ACK in the same cycle, then over-sized ACK
        csr_wr(2'd0, 32'h5);
        push(10, 16'h4000, acc);
        bus.snk_valid = 1'b1; bus.snk_data = 16'h40AA;
        bus.csr_address = 2'd2; bus.csr_writedata = 32'd4; bus.csr_write = 1'b1;
        @(posedge clk); #1;
        bus.snk_valid = 1'b0; bus.csr_write = 1'b0;
        csr_rd(2'd1, rd);
        check("ack_acc_status", rd, status_of(11, 7, 0));
        csr_wr(2'd2, 32'd200);
        csr_rd(2'd1, rd);
        check("ack_big_status", rd, status_of(11, 0, 0));

        // Watermark interrupt
        csr_wr(2'd3, 32'd8);
        csr_wr(2'd0, 32'h5);
        push(8, 16'h5000, acc);
        check("irq_at_8th", bus.irq, 1'b0);
        @(posedge clk); #1;
        check("irq_rise", bus.irq, HAS_WM);
        csr_wr(2'd2, 32'd1);
        check("irq_hold", bus.irq, HAS_WM);
        @(posedge clk); #1;
        check("irq_fall", bus.irq, 1'b0);
        csr_rd(2'd3, rd);
        check("wm_read", rd, HAS_WM ? 32'd8 : 32'd0);

        // Reset in the cycle after an accept kills the pending write
        bus.snk_valid = 1'b1; bus.snk_data = 16'hBEEF;
        @(posedge clk); #1;
        bus.snk_valid = 1'b0;
        check("rstw_pending", bus.ram_write, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rstw_write", bus.ram_write, 1'b0);
        check("rstw_cs", bus.ram_chipselect, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        csr_rd(2'd1, rd);
        check("rstw_status", rd, 32'd0);
        csr_rd(2'd0, rd);
        check("rstw_ctrl", rd, 32'd0);

        do_reset();
        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sample_ring_writer.md
# sample_ring_writer

Stream-to-RAM ring-buffer writer that sits directly upstream of the 128×16 dual-port on-chip RAM. It accepts 16-bit samples on a valid/ready sink and writes them sequentially into the RAM's second port, wrapping at 128 words. A small Avalon-MM CSR slave lets the Nios II track fill level, acknowledge consumed words, and take a watermark interrupt; the CPU reads the samples through the RAM's first port.

## Interface
- `ADDR_W`, 7: RAM word-address width; depth is 2^ADDR_W = 128.
- `DATA_W`, 16: sample and RAM word width.
- `WM_RESET`, 64: reset value of the WATERMARK register.

Ports (clock and reset first):
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `snk_valid` in 1: sample valid.
- `snk_data` in 16: sample data.
- `snk_ready` out 1: block can accept a sample.
- `ram_address` out 7: RAM port-2 address.
- `ram_chipselect` out 1: RAM port-2 chipselect.
- `ram_write` out 1: RAM port-2 write.
- `ram_writedata` out 16: RAM port-2 write data.
- `ram_byteenable` out 2: constant 2'b11.
- `ram_clken` out 1: constant 1.
- `csr_address` in 2: CSR word select.
- `csr_read` in 1: CSR read strobe.
- `csr_write` in 1: CSR write strobe.
- `csr_writedata` in 32: CSR write data.
- `csr_readdata` out 32: CSR read data, registered.
- `irq` out 1: level-sensitive watermark interrupt.

## Operation
- CSR 0, CTRL (R/W):
  - bit0 ENABLE.
  - bit1 MODE: 0 = stop when full, 1 = overwrite oldest.
  - bit2 CLEAR: write-1 pulse, reads as 0.
- CSR 1, STATUS (RO):
  - [6:0] wr_ptr.
  - [14:8] rd_ptr, where rd_ptr = (wr_ptr − count) mod 128.
  - [23:16] count, range 0..128.
  - bit24 OVERFLOW (sticky).
  - bit25 FULL, defined as count == 128.
- CSR 2, ACK (WO): writing N consumes min(N[7:0], count) words. Reads return 0.
- CSR 3, WATERMARK (R/W, [7:0]).
- `snk_ready` = ENABLE & ~(MODE==0 & FULL) & ~clear_this_cycle.
- Accept (`snk_valid` & `snk_ready`) at edge t:
  - Latch data and address = wr_ptr into the output register.
  - wr_ptr ← wr_ptr+1, wrapping 127→0.
  - count ← count+1, saturating at 128.
- Overwrite mode while FULL: the accept is taken, count stays 128, rd_ptr advances, and OVERFLOW is set.
- Accept and ACK in the same cycle: count ← count − min(N, count_old) + 1, saturating at 128.
- CLEAR zeroes wr_ptr, count and OVERFLOW. It takes priority over a same-cycle accept, which is not taken because ready is low. CTRL and WATERMARK are kept.
- Clearing ENABLE stops accepts only. A write already latched still completes.
- Reset values: all RAM outputs 0 except `ram_byteenable`=2'b11 and `ram_clken`=1; `snk_ready`=0; `csr_readdata`=0; `irq`=0; CTRL=0; pointers and count 0; WATERMARK=`WM_RESET`.
- An asserted `reset_n` mid-write drops the pending RAM write immediately.

## Timing
- Sample accepted at edge t: `ram_chipselect`=`ram_write`=1 for exactly the cycle after t, with address and data stable. The RAM latches the write at edge t+1.
- Throughput is one sample per clock; back-to-back accepts produce back-to-back writes.
- STATUS reflects an accept or ACK from the edge it occurs on.
- CSR read: `csr_readdata` is valid the cycle after `csr_read` (read latency 1, no waitrequest).
- CSR write: takes effect at the `csr_write` edge.
- `irq` is registered and updates one cycle after count changes.

## Configuration
- `SAMPLE_RING_IRQ_EN` defined:
  - `irq` = (WATERMARK != 0) & (count >= WATERMARK).
  - The level stays asserted until ACKs drop count below WATERMARK.
- `SAMPLE_RING_IRQ_EN` undefined:
  - `irq` is tied to 0.
  - The WATERMARK register is not implemented: it reads 0 and writes are ignored.

## Test plan
- Reset then ENABLE=1, stream 5 samples 0x1000..0x1004 -> RAM writes to addresses 0..4 one cycle after each accept; STATUS count=5, wr_ptr=5.
- MODE=0, push 130 samples with `snk_valid` held -> `snk_ready` drops after the 128th accept; FULL=1, OVERFLOW=0, wr_ptr=0.
- MODE=1, push 130 samples -> all accepted, count=128, OVERFLOW=1, rd_ptr=2, and addresses 0 and 1 overwritten with samples 129 and 130.
- count=10, then ACK N=4 in the same cycle as an accept -> count=7. A following ACK of 200 -> count=0 with no underflow.
- With `SAMPLE_RING_IRQ_EN`, WATERMARK=8 -> `irq` rises one cycle after the 8th accept; ACK of 1 -> `irq` falls. Without the macro, `irq` stays 0 and WATERMARK reads 0.
- Deassert `reset_n` in the cycle after an accept -> `ram_write` low immediately, STATUS reads 0 after release.
